// File: rtl/core_dispatcher.sv
// core_dispatcher: accepts one task, seeds the selected cores, starts them and waits for completion or timeout.
module core_dispatcher #(
  parameter int NUM_OF_CORES = 4,
  parameter int REG_SIZE = 8,
  parameter int INSN_SIZE = 16,
  parameter int INSN_NUM = 16,
  parameter int START_GUARD = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic task_valid,
  output logic task_ready,
  input  logic [NUM_OF_CORES-1:0] task_mask,
  input  logic [REG_SIZE-1:0] task_r0_base,
  input  logic [INSN_NUM*INSN_SIZE-1:0] task_insn,
  output logic [INSN_NUM*INSN_SIZE-1:0] insn_data,
  output logic [NUM_OF_CORES-1:0] start,
  output logic [NUM_OF_CORES-1:0] init_r0_flag,
  output logic [REG_SIZE*NUM_OF_CORES-1:0] init_r0_data,
  input  logic [NUM_OF_CORES-1:0] core_ready,
  output logic done,
  output logic timeout_err,
  output logic [15:0] busy_cycles
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, CHECK, START, GUARD, RUN, DONE} state_t;
  state_t state, nxt;
  logic [NUM_OF_CORES-1:0] mask;
  logic [3:0] guard;
  logic [TW-1:0] run_cnt;
  logic all_ready, tmo;
  assign all_ready = (core_ready & mask) == mask;
  assign tmo = TIMEOUT != 0 && run_cnt == TW'(TIMEOUT - 1);
  assign task_ready = state == IDLE;
  assign start = state == START ? mask : '0;
  assign init_r0_flag = start;
  assign done = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (task_valid) nxt = task_mask == '0 ? DONE : CHECK;
      CHECK: if (all_ready) nxt = START;
      START: nxt = GUARD;
      GUARD: if (guard <= 4'd1) nxt = RUN;
      RUN:   if (all_ready || tmo) nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mask <= '0;
      insn_data <= '0;
      init_r0_data <= '0;
      guard <= '0;
      run_cnt <= '0;
      busy_cycles <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && task_valid) begin
        mask <= task_mask;
        insn_data <= task_insn;
        timeout_err <= 1'b0;
        for (int i = 0; i < NUM_OF_CORES; i++)
          init_r0_data[i*REG_SIZE +: REG_SIZE] <= task_r0_base + REG_SIZE'(i);
      end
      // the START cycle counts as the first guard cycle
      if (state == START) begin
        guard <= 4'(START_GUARD - 1);
        run_cnt <= '0;
        busy_cycles <= 16'd1;
      end
      if (state == GUARD) guard <= guard - 4'd1;
      if (state == RUN) run_cnt <= run_cnt + TW'(1);
      if (state == GUARD || state == RUN) busy_cycles <= busy_cycles + 16'(busy_cycles != 16'hFFFF);
      if (state == RUN && !all_ready && tmo) timeout_err <= 1'b1;
    end
  end
endmodule
